// File: rtl/arm_pipe_pkg.sv
// Shared pipeline defaults for the ID-stage register file and its write scoreboard.
package arm_pipe_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int NUM_REGS_DEF = 16;
    localparam int CNT_W_DEF    = 2;

    // Address width for a register count; a single register still gets one address bit.
    function automatic int addr_w(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

    localparam int ADDR_W_DEF = addr_w(NUM_REGS_DEF);

endpackage

// File: rtl/sb_counter.sv
// Per-register count of in-flight writes, with flags for the scoreboard.
module sb_counter
    import arm_pipe_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic dec_i,
    output logic at_max_o,
    output logic nonzero_o,
    output logic last_o,
    output logic underflow_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             do_dec;

    assign nonzero_o   = (cnt_q != '0);
    assign last_o      = (cnt_q == CNT_W'(1));
    assign at_max_o    = &cnt_q;
    assign do_dec      = dec_i && nonzero_o;
    // A write-back with nothing outstanding, unless an issue arrives the same cycle.
    assign underflow_o = dec_i && !nonzero_o && !inc_i;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !do_dec) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (do_dec && !inc_i) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/id_regfile_scoreboard.sv
// ID-stage register file with write-first bypass and a per-register pending-write
// scoreboard that raises hazard for RAW dependencies and counter saturation.
module id_regfile_scoreboard
    import arm_pipe_pkg::*;
#(
    parameter int  DATA_W   = DATA_W_DEF,
    parameter int  NUM_REGS = NUM_REGS_DEF,
    parameter int  CNT_W    = CNT_W_DEF,
    localparam int ADDR_W   = addr_w(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic              issue_wb_en,
    input  logic [ADDR_W-1:0] issue_dest,
    input  logic              flush,
    input  logic [ADDR_W-1:0] src1_addr,
    input  logic [ADDR_W-1:0] src2_addr,
    input  logic              two_src,
    output logic [DATA_W-1:0] rd1_data,
    output logic [DATA_W-1:0] rd2_data,
    output logic              hazard,
    output logic              issue_fire,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_value,
    output logic              sb_err
);

    logic [DATA_W-1:0]   mem_q [NUM_REGS];
    logic [NUM_REGS-1:0] wb_hit;
    logic [NUM_REGS-1:0] inc_hit;
    logic [NUM_REGS-1:0] at_max;
    logic [NUM_REGS-1:0] nonzero;
    logic [NUM_REGS-1:0] last;
    logic [NUM_REGS-1:0] underflow;
    logic [NUM_REGS-1:0] pend;
    logic                sb_err_q;

    assign rd1_data = (wb_en && (wb_dest == src1_addr)) ? wb_value : mem_q[src1_addr];
    assign rd2_data = (wb_en && (wb_dest == src2_addr)) ? wb_value : mem_q[src2_addr];

    assign hazard = issue_valid &&
                    (pend[src1_addr] ||
                     (two_src && pend[src2_addr]) ||
                     (issue_wb_en && at_max[issue_dest]));

    assign issue_fire = issue_valid && !hazard && !flush;
    assign sb_err     = sb_err_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            assign wb_hit[gi]  = wb_en && (wb_dest == ADDR_W'(gi));
            assign inc_hit[gi] = issue_fire && issue_wb_en && (issue_dest == ADDR_W'(gi));
            // The final outstanding write landing this cycle is bypassed, so it no longer blocks.
            assign pend[gi]    = nonzero[gi] && !(wb_hit[gi] && last[gi]);

            sb_counter #(
                .CNT_W(CNT_W)
            ) u_cnt (
                .clk        (clk),
                .rst        (rst),
                .inc_i      (inc_hit[gi]),
                .dec_i      (wb_hit[gi]),
                .at_max_o   (at_max[gi]),
                .nonzero_o  (nonzero[gi]),
                .last_o     (last[gi]),
                .underflow_o(underflow[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wb_en) begin
            mem_q[wb_dest] <= wb_value;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sb_err_q <= 1'b0;
        end else if (|underflow) begin
            sb_err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_id_regfile_scoreboard.sv
// Scenario tasks plus a randomized run checked against a behavioural scoreboard model.
module tb_id_regfile_scoreboard;

    localparam int MAXC = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_wb_en, flush, two_src, wb_en;
    logic [3:0]  issue_dest, src1_addr, src2_addr, wb_dest;
    logic [31:0] wb_value;
    logic [31:0] rd1_data, rd2_data;
    logic        hazard, issue_fire, sb_err;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] model_mem [16];
    int          model_cnt [16];
    bit          model_err;

    id_regfile_scoreboard dut (
        .clk        (clk),
        .rst        (rst),
        .issue_valid(issue_valid),
        .issue_wb_en(issue_wb_en),
        .issue_dest (issue_dest),
        .flush      (flush),
        .src1_addr  (src1_addr),
        .src2_addr  (src2_addr),
        .two_src    (two_src),
        .rd1_data   (rd1_data),
        .rd2_data   (rd2_data),
        .hazard     (hazard),
        .issue_fire (issue_fire),
        .wb_en      (wb_en),
        .wb_dest    (wb_dest),
        .wb_value   (wb_value),
        .sb_err     (sb_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit m_pend(input int r);
        return (model_cnt[r] > 0) && !(wb_en && int'(wb_dest) == r && model_cnt[r] == 1);
    endfunction

    function automatic bit m_hazard();
        return issue_valid && (m_pend(int'(src1_addr)) ||
                               (two_src && m_pend(int'(src2_addr))) ||
                               (issue_wb_en && model_cnt[int'(issue_dest)] == MAXC));
    endfunction

    function automatic bit m_fire();
        return issue_valid && !m_hazard() && !flush;
    endfunction

    function automatic logic [31:0] m_rd(input logic [3:0] a);
        return (wb_en && wb_dest == a) ? wb_value : model_mem[int'(a)];
    endfunction

    task automatic model_edge();
        bit fire;
        int d, w;
        if (!rst) begin
            for (int r = 0; r < 16; r++) begin
                model_mem[r] = '0;
                model_cnt[r] = 0;
            end
            model_err = 1'b0;
        end else begin
            fire = m_fire();
            d = int'(issue_dest);
            w = int'(wb_dest);
            if (wb_en) begin
                if (model_cnt[w] == 0 && !(fire && issue_wb_en && d == w)) model_err = 1'b1;
                if (model_cnt[w] > 0) model_cnt[w]--;
                model_mem[w] = wb_value;
            end
            if (fire && issue_wb_en) model_cnt[d]++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 1'b1; issue_valid = 1'b0; issue_wb_en = 1'b0; issue_dest = '0;
        flush = 1'b0; src1_addr = '0; src2_addr = '0; two_src = 1'b0;
        wb_en = 1'b0; wb_dest = '0; wb_value = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle(); rst = 1'b0; tick(); rst = 1'b1;
        for (int a = 0; a < 16; a += 5) begin
            src1_addr = 4'(a); src2_addr = 4'(15 - a); two_src = 1'b1;
            issue_valid = 1'b1; issue_wb_en = 1'b1; issue_dest = 4'(a); flush = 1'b0;
            #1;
            tests_run++; if (rd1_data !== 32'h0) begin tests_failed++; $display("FAIL reset_rd1 a=%0d got %h want 0", a, rd1_data); end
            tests_run++; if (rd2_data !== 32'h0) begin tests_failed++; $display("FAIL reset_rd2 a=%0d got %h want 0", a, rd2_data); end
            tests_run++; if (hazard !== 1'b0) begin tests_failed++; $display("FAIL reset_hazard got %b want 0", hazard); end
            tests_run++; if (issue_fire !== 1'b1) begin tests_failed++; $display("FAIL reset_fire got %b want 1", issue_fire); end
            tests_run++; if (sb_err !== 1'b0) begin tests_failed++; $display("FAIL reset_sb_err got %b want 0", sb_err); end
            flush = 1'b1; #1;
            tests_run++; if (issue_fire !== 1'b0) begin tests_failed++; $display("FAIL reset_fire_flush got %b want 0", issue_fire); end
        end
        idle();
        $display("[TB] test_reset done");
    endtask

    task automatic test_bypass();
        idle(); wb_en = 1'b1; wb_dest = 4'd2; wb_value = 32'h0000_00A5; src1_addr = 4'd2; #1;
        tests_run++; if (rd1_data !== 32'hA5) begin tests_failed++; $display("FAIL bypass_rd1 got %h want 000000a5", rd1_data); end
        tests_run++; if (sb_err !== 1'b0) begin tests_failed++; $display("FAIL bypass_sb_err_pre got %b want 0", sb_err); end
        tick();
        wb_en = 1'b0; wb_value = 32'hFFFF_FFFF; src2_addr = 4'd2; #1;
        tests_run++; if (rd1_data !== 32'hA5) begin tests_failed++; $display("FAIL array_rd1 got %h want 000000a5", rd1_data); end
        tests_run++; if (rd2_data !== 32'hA5) begin tests_failed++; $display("FAIL array_rd2 got %h want 000000a5", rd2_data); end
        // That write-back had nothing outstanding, so the sticky flag is now expected.
        tests_run++; if (sb_err !== 1'b1) begin tests_failed++; $display("FAIL bypass_sb_err_post got %b want 1", sb_err); end
        idle(); rst = 1'b0; tick(); idle();
        $display("[TB] test_bypass done");
    endtask

    task automatic test_raw_stall();
        idle(); issue_valid = 1'b1; issue_wb_en = 1'b1; issue_dest = 4'd3; #1;
        tests_run++; if (issue_fire !== 1'b1) begin tests_failed++; $display("FAIL raw_issue_fire got %b want 1", issue_fire); end
        tick();
        issue_wb_en = 1'b0; issue_dest = 4'd0; src1_addr = 4'd3;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests_run++; if (hazard !== 1'b1) begin tests_failed++; $display("FAIL raw_hazard k=%0d got %b want 1", k, hazard); end
            tests_run++; if (issue_fire !== 1'b0) begin tests_failed++; $display("FAIL raw_fire k=%0d got %b want 0", k, issue_fire); end
            tick();
        end
        wb_en = 1'b1; wb_dest = 4'd3; wb_value = 32'h1234_5678; #1;
        tests_run++; if (hazard !== 1'b0) begin tests_failed++; $display("FAIL raw_wb_hazard got %b want 0", hazard); end
        tests_run++; if (issue_fire !== 1'b1) begin tests_failed++; $display("FAIL raw_wb_fire got %b want 1", issue_fire); end
        tests_run++; if (rd1_data !== 32'h1234_5678) begin tests_failed++; $display("FAIL raw_wb_rd1 got %h want 12345678", rd1_data); end
        tick(); idle();
        $display("[TB] test_raw_stall done");
    endtask

    task automatic test_two_src();
        idle(); issue_valid = 1'b1; issue_wb_en = 1'b1; issue_dest = 4'd3; tick();
        issue_wb_en = 1'b0; issue_dest = 4'd0; src1_addr = 4'd0; src2_addr = 4'd3; two_src = 1'b0; #1;
        tests_run++; if (hazard !== 1'b0) begin tests_failed++; $display("FAIL two_src0_hazard got %b want 0", hazard); end
        two_src = 1'b1; #1;
        tests_run++; if (hazard !== 1'b1) begin tests_failed++; $display("FAIL two_src1_hazard got %b want 1", hazard); end
        wb_en = 1'b1; wb_dest = 4'd3; wb_value = 32'hCAFE_0003; #1;
        tests_run++; if (hazard !== 1'b0) begin tests_failed++; $display("FAIL two_src_wb_hazard got %b want 0", hazard); end
        tests_run++; if (rd2_data !== 32'hCAFE_0003) begin tests_failed++; $display("FAIL two_src_wb_rd2 got %h want cafe0003", rd2_data); end
        tick(); idle();
        $display("[TB] test_two_src done");
    endtask

    task automatic test_max_count();
        idle(); issue_valid = 1'b1; issue_wb_en = 1'b1; issue_dest = 4'd4;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests_run++; if (issue_fire !== 1'b1) begin tests_failed++; $display("FAIL max_issue%0d_fire got %b want 1", k, issue_fire); end
            tick();
        end
        #1;
        tests_run++; if (hazard !== 1'b1) begin tests_failed++; $display("FAIL max_full_hazard got %b want 1", hazard); end
        tests_run++; if (issue_fire !== 1'b0) begin tests_failed++; $display("FAIL max_full_fire got %b want 0", issue_fire); end
        tick();
        issue_valid = 1'b0; wb_en = 1'b1; wb_dest = 4'd4; wb_value = 32'h4; tick();
        wb_en = 1'b0; issue_valid = 1'b1; #1;
        tests_run++; if (hazard !== 1'b0) begin tests_failed++; $display("FAIL max_after_wb_hazard got %b want 0", hazard); end
        tests_run++; if (issue_fire !== 1'b1) begin tests_failed++; $display("FAIL max_after_wb_fire got %b want 1", issue_fire); end
        tick();
        issue_valid = 1'b0; wb_en = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        wb_en = 1'b0; #1;
        tests_run++; if (sb_err !== 1'b0) begin tests_failed++; $display("FAIL max_drain_sb_err got %b want 0", sb_err); end
        idle();
        $display("[TB] test_max_count done");
    endtask

    task automatic test_flush_underflow();
        idle(); flush = 1'b1; issue_valid = 1'b1; issue_wb_en = 1'b1; issue_dest = 4'd5; #1;
        tests_run++; if (issue_fire !== 1'b0) begin tests_failed++; $display("FAIL flush_fire got %b want 0", issue_fire); end
        tests_run++; if (hazard !== 1'b0) begin tests_failed++; $display("FAIL flush_hazard got %b want 0", hazard); end
        tick();
        flush = 1'b0; issue_wb_en = 1'b0; issue_dest = 4'd0; src1_addr = 4'd5; #1;
        tests_run++; if (hazard !== 1'b0) begin tests_failed++; $display("FAIL flush_cnt_hazard got %b want 0", hazard); end
        issue_valid = 1'b0; wb_en = 1'b1; wb_dest = 4'd5; wb_value = 32'h55; #1;
        tests_run++; if (sb_err !== 1'b0) begin tests_failed++; $display("FAIL underflow_pre got %b want 0", sb_err); end
        tick();
        wb_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests_run++; if (sb_err !== 1'b1) begin tests_failed++; $display("FAIL underflow_sticky k=%0d got %b want 1", k, sb_err); end
            tick();
        end
        tests_run++; if (rd1_data !== 32'h55) begin tests_failed++; $display("FAIL underflow_data got %h want 00000055", rd1_data); end
        idle();
        $display("[TB] test_flush_underflow done");
    endtask

    task automatic test_reset_midflight();
        idle(); wb_en = 1'b1; wb_dest = 4'd2; wb_value = 32'hA5; tick(); idle();
        issue_valid = 1'b1; issue_wb_en = 1'b1; issue_dest = 4'd6; tick(); tick();
        issue_wb_en = 1'b0; src1_addr = 4'd6; #1;
        tests_run++; if (hazard !== 1'b1) begin tests_failed++; $display("FAIL mid_pending_hazard got %b want 1", hazard); end
        rst = 1'b0; issue_wb_en = 1'b1; wb_en = 1'b1; wb_dest = 4'd7; wb_value = 32'hDEAD; tick();
        rst = 1'b1; wb_en = 1'b0; two_src = 1'b1; src2_addr = 4'd7; #1;
        tests_run++; if (hazard !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_hazard got %b want 0", hazard); end
        tests_run++; if (issue_fire !== 1'b1) begin tests_failed++; $display("FAIL mid_rst_fire got %b want 1", issue_fire); end
        tests_run++; if (sb_err !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_sb_err got %b want 0", sb_err); end
        tests_run++; if (rd2_data !== 32'h0) begin tests_failed++; $display("FAIL mid_rst_wb_ignored got %h want 0", rd2_data); end
        src2_addr = 4'd2; #1;
        tests_run++; if (rd2_data !== 32'h0) begin tests_failed++; $display("FAIL mid_rst_array got %h want 0", rd2_data); end
        idle();
        $display("[TB] test_reset_midflight done");
    endtask

    task automatic test_random();
        int cand[$];
        for (int n = 0; n < 400; n++) begin
            rst         = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            issue_valid = ($urandom_range(0, 3) != 0);
            issue_wb_en = ($urandom_range(0, 3) != 0);
            issue_dest  = 4'($urandom_range(0, 7));
            flush       = ($urandom_range(0, 9) == 0);
            src1_addr   = 4'($urandom_range(0, 7));
            src2_addr   = 4'($urandom_range(0, 7));
            two_src     = 1'($urandom);
            wb_en       = ($urandom_range(0, 2) != 0);
            wb_value    = $urandom;
            cand.delete();
            for (int r = 0; r < 16; r++) if (model_cnt[r] > 0) cand.push_back(r);
            if (cand.size() > 0 && $urandom_range(0, 9) < 8)
                wb_dest = 4'(cand[$urandom_range(0, cand.size() - 1)]);
            else
                wb_dest = 4'($urandom_range(0, 7));
            #1;
            if (rst) begin
                tests_run++; if (rd1_data !== m_rd(src1_addr)) begin tests_failed++; $display("FAIL rnd_rd1 n=%0d got %h want %h", n, rd1_data, m_rd(src1_addr)); end
                tests_run++; if (rd2_data !== m_rd(src2_addr)) begin tests_failed++; $display("FAIL rnd_rd2 n=%0d got %h want %h", n, rd2_data, m_rd(src2_addr)); end
                tests_run++; if (hazard !== m_hazard()) begin tests_failed++; $display("FAIL rnd_hazard n=%0d got %b want %b", n, hazard, m_hazard()); end
                tests_run++; if (issue_fire !== m_fire()) begin tests_failed++; $display("FAIL rnd_fire n=%0d got %b want %b", n, issue_fire, m_fire()); end
                tests_run++; if (sb_err !== model_err) begin tests_failed++; $display("FAIL rnd_sb_err n=%0d got %b want %b", n, sb_err, model_err); end
            end
            tick();
        end
        idle();
        $display("[TB] test_random done");
    endtask

    initial begin
        for (int r = 0; r < 16; r++) begin
            model_mem[r] = '0;
            model_cnt[r] = 0;
        end
        model_err = 1'b0;
        test_reset();
        test_bypass();
        test_raw_stall();
        test_two_src();
        test_max_count();
        test_flush_underflow();
        test_reset_midflight();
        idle(); rst = 1'b0; tick(); idle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/id_regfile_scoreboard.md
ID_REGFILE_SCOREBOARD -- requirements
Module: id_regfile_scoreboard

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register data width.
REQ-002 The block SHALL have parameter NUM_REGS, default 16, architectural register count; ADDR_W = clog2(NUM_REGS).
REQ-003 The block SHALL have parameter CNT_W, default 2, width of each per-register pending-write counter (max 2^CNT_W-1 in flight).
REQ-004 The block SHALL have ports, one per line:
  clk  in  1  rising-edge clock, sole clock
  rst  in  1  synchronous reset, active-low
  issue_valid  in  1  decoded instruction present in ID this cycle
  issue_wb_en  in  1  that instruction writes a register
  issue_dest  in  ADDR_W  its destination register
  flush  in  1  squash the ID instruction this cycle
  src1_addr  in  ADDR_W  first source (Rn)
  src2_addr  in  ADDR_W  second source (Rm/Rd)
  two_src  in  1  src2 is a real operand
  rd1_data  out  DATA_W  value of src1
  rd2_data  out  DATA_W  value of src2
  hazard  out  1  ID must stall
  issue_fire  out  1  instruction accepted this cycle
  wb_en  in  1  write-back valid
  wb_dest  in  ADDR_W  write-back register
  wb_value  in  DATA_W  write-back data
  sb_err  out  1  sticky scoreboard underflow flag

Function
REQ-005 Reads SHALL be combinational: rdN_data = array[srcN_addr], except when wb_en and wb_dest==srcN_addr, then rdN_data = wb_value (write-first bypass).
REQ-006 Write-back SHALL update array[wb_dest] <= wb_value at the rising edge when wb_en=1.
REQ-007 Per register r, pend(r) SHALL be 1 when cnt[r]>0 and not (wb_en and wb_dest==r and cnt[r]==1).
REQ-008 hazard SHALL be combinational: issue_valid and (pend(src1_addr) or (two_src and pend(src2_addr)) or (issue_wb_en and cnt[issue_dest]==max)).
REQ-009 issue_fire SHALL equal issue_valid and not hazard and not flush.
REQ-010 cnt[r] SHALL increment by 1 when issue_fire and issue_wb_en and issue_dest==r, and decrement by 1 when wb_en and wb_dest==r and cnt[r]>0; both in one cycle leave cnt[r] unchanged.
REQ-011 Write-back to a register with cnt==0 (no simultaneous increment) SHALL still write data, leave cnt at 0, and set sb_err to 1 on the next edge; sb_err clears only on reset.
REQ-012 Counters SHALL never wrap: the max-count condition in REQ-008 stalls issue instead.
REQ-013 flush SHALL block counter increment but SHALL NOT affect write-back, reads or hazard.
REQ-014 Latency: a write-back is visible on rd outputs in the same cycle (bypass) and from the array from the next cycle.

Reset
REQ-015 With rst=0 at a rising edge, all array entries, all cnt[] and sb_err SHALL become 0; write-back and issue in that cycle SHALL be ignored.
REQ-016 After reset, rd1_data/rd2_data SHALL read 0 for any address not being bypassed, hazard=0, issue_fire=issue_valid and not flush.

Structure
REQ-017 DATA_W, NUM_REGS, CNT_W defaults and ADDR_W derivation SHALL live in shared package arm_pipe_pkg.
REQ-018 The per-register counter (inc, dec, max, nonzero, underflow) SHALL be sub-module sb_counter, instantiated NUM_REGS times.

Verification
REQ-019 Reset, then wb_en=1 wb_dest=2 wb_value=0x0000_00A5 -> rd1_data=0xA5 same cycle with src1_addr=2; array holds 0xA5 next cycle.
REQ-020 Issue dest=3 (wb_en), next cycle src1_addr=3 -> hazard=1, issue_fire=0 until wb_dest=3 arrives; in that wb cycle hazard=0 and rd1_data=wb_value.
REQ-021 two_src=0, src2_addr=3 pending -> hazard=0; two_src=1 -> hazard=1.
REQ-022 Three issues to dest=4 without write-back -> cnt=3, fourth issue to dest=4 gives hazard=1; one wb to 4 -> cnt=2, issue accepted.
REQ-023 flush=1 with issue_valid, issue_wb_en, dest=5 -> issue_fire=0, cnt[5] stays 0; wb to 5 then sets sb_err=1, held until rst=0.
REQ-024 rst=0 for one cycle while cnt[6]=2 -> all counters 0, hazard=0, sb_err=0 on release.
